// File: rtl/i2c_master_fsm.sv
// rtl/i2c_master_fsm.sv - I2C master bit-level control FSM (address, write/read bytes, ACK handling)
module i2c_master_fsm #(
  parameter int DATA_SIZE = 8,
  parameter int ADDR_SIZE = 7,
  localparam int MAX_SIZE = (DATA_SIZE > ADDR_SIZE) ? DATA_SIZE : ADDR_SIZE,
  localparam int IDX_W    = (MAX_SIZE > 1) ? $clog2(MAX_SIZE) : 1
) (
  input  logic             i2c_core_clk_i,
  input  logic             i2c_core_rst_i,
  input  logic             enable_i,
  input  logic             rw_i,
  input  logic             sda_i,
  input  logic             tx_empty_i,
  input  logic             rx_full_i,
  output logic             sda_low_o,
  output logic             write_addr_en_o,
  output logic             write_data_en_o,
  output logic             receive_data_en_o,
  output logic             rw_bit_en_o,
  output logic [IDX_W-1:0] bit_idx_o,
  output logic             tx_rd_en_o,
  output logic             rx_wr_en_o,
  output logic             stop_en_o,
  output logic             busy_o,
  output logic             nack_o,
  output logic             done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_ADDR, S_RW_BIT, S_ADDR_ACK,
    S_WR_DATA, S_WR_ACK, S_RD_DATA, S_RD_ACK, S_STOP
  } state_e;

  localparam logic [IDX_W-1:0] ADDR_LAST = IDX_W'(ADDR_SIZE - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_SIZE - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             rw_q, rw_d;
  logic             nack_q, nack_d;

  // State, bit counter, latched direction and sticky NACK flag
  always_ff @(posedge i2c_core_clk_i or posedge i2c_core_rst_i) begin
    if (i2c_core_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rw_q    <= 1'b0;
      nack_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rw_q    <= rw_d;
      nack_q  <= nack_d;
    end
  end

  // Next-state and per-state datapath controls; ACK decisions only at ACK states
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    rw_d              = rw_q;
    nack_d            = nack_q;
    sda_low_o         = 1'b0;
    write_addr_en_o   = 1'b0;
    write_data_en_o   = 1'b0;
    receive_data_en_o = 1'b0;
    rw_bit_en_o       = 1'b0;
    bit_idx_o         = '0;
    tx_rd_en_o        = 1'b0;
    rx_wr_en_o        = 1'b0;
    stop_en_o         = 1'b0;
    done_o            = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable_i) begin
          rw_d    = rw_i;
          nack_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        sda_low_o = 1'b1;
        cnt_d     = ADDR_LAST;
        state_d   = S_ADDR;
      end
      S_ADDR: begin
        write_addr_en_o = 1'b1;
        bit_idx_o       = cnt_q;
        if (cnt_q == '0) state_d = S_RW_BIT;
        else             cnt_d   = cnt_q - IDX_W'(1);
      end
      S_RW_BIT: begin
        rw_bit_en_o = 1'b1;
        state_d     = S_ADDR_ACK;
      end
      S_ADDR_ACK: begin
        cnt_d = DATA_LAST;
        if (sda_i) begin
          nack_d  = 1'b1;
          state_d = S_STOP;
        end else if (rw_q) begin
          state_d = S_RD_DATA;
        end else if (!tx_empty_i) begin
          state_d = S_WR_DATA;
        end else begin
          state_d = S_STOP;
        end
      end
      S_WR_DATA: begin
        write_data_en_o = 1'b1;
        bit_idx_o       = cnt_q;
        if (cnt_q == '0) begin
          tx_rd_en_o = 1'b1;
          state_d    = S_WR_ACK;
        end else begin
          cnt_d = cnt_q - IDX_W'(1);
        end
      end
      S_WR_ACK: begin
        cnt_d = DATA_LAST;
        if (sda_i) begin
          nack_d  = 1'b1;
          state_d = S_STOP;
        end else if (enable_i && !tx_empty_i) begin
          state_d = S_WR_DATA;
        end else begin
          state_d = S_STOP;
        end
      end
      S_RD_DATA: begin
        receive_data_en_o = 1'b1;
        bit_idx_o         = cnt_q;
        if (cnt_q == '0) state_d = S_RD_ACK;
        else             cnt_d   = cnt_q - IDX_W'(1);
      end
      S_RD_ACK: begin
        // A full RX FIFO drops the byte and forces a master NACK
        cnt_d      = DATA_LAST;
        rx_wr_en_o = !rx_full_i;
        if (enable_i && !rx_full_i) begin
          sda_low_o = 1'b1;
          state_d   = S_RD_DATA;
        end else begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        stop_en_o = 1'b1;
        done_o    = 1'b1;
        cnt_d     = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_o = (state_q != S_IDLE);
  assign nack_o = nack_q;

endmodule

// File: tb/tb_i2c_master_fsm.sv
// tb/tb_i2c_master_fsm.sv - randomized transaction-level check of i2c_master_fsm
module tb_i2c_master_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, rw = 1'b0, sda = 1'b1, txe = 1'b1, rxf = 1'b0;
  logic       sda_low, wa, wd, rd, rwb, txrd, rxwr, stp, busy, nack, done;
  logic [2:0] idx;

  i2c_master_fsm #(.DATA_SIZE(8), .ADDR_SIZE(7)) dut (
    .i2c_core_clk_i(clk), .i2c_core_rst_i(rst), .enable_i(en), .rw_i(rw),
    .sda_i(sda), .tx_empty_i(txe), .rx_full_i(rxf), .sda_low_o(sda_low),
    .write_addr_en_o(wa), .write_data_en_o(wd), .receive_data_en_o(rd),
    .rw_bit_en_o(rwb), .bit_idx_o(idx), .tx_rd_en_o(txrd), .rx_wr_en_o(rxwr),
    .stop_en_o(stp), .busy_o(busy), .nack_o(nack), .done_o(done)
  );

  always #5 clk = ~clk;

  // {sda_low, wa, wd, rd, rwb, idx[2:0], txrd, rxwr, stop, busy, nack, done}
  wire [13:0] obs = {sda_low, wa, wd, rd, rwb, idx, txrd, rxwr, stp, busy, nack, done};

  int n_checks = 0;
  int n_errors = 0;
  int done_at;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one transaction expanded into per-cycle stimulus and expected outputs
  logic [4:0]  stim_q[$];   // {en, sda, tx_empty, rx_full, rw}
  logic [13:0] exp_q[$];
  logic        model_nack = 1'b0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [13:0] ev(input logic sl, w_a, w_d, r_d, r_w, input int bi,
                                     input logic t_rd, r_wr, st);
    return {sl, w_a, w_d, r_d, r_w, 3'(bi), t_rd, r_wr, st, 1'b1, model_nack, st};
  endfunction

  function automatic logic [13:0] ev_idle();
    return {12'b0, model_nack, 1'b0};
  endfunction

  task automatic push(input logic e, s, t, f, w, input logic [13:0] x);
    stim_q.push_back({e, s, t, f, w});
    exp_q.push_back(x);
  endtask

  // mode 0 random, 1 write one byte, 2 address NACK, 3 read two bytes, 4 read with RX full
  task automatic build_txn(input int mode);
    logic dir, anack, empty, go, nk, e, f, ack;
    int   nbyte;
    dir = (mode == 0) ? rb() : (mode >= 3);
    push(1'b1, rb(), rb(), rb(), dir, ev_idle());
    model_nack = 1'b0;
    push(rb(), rb(), rb(), rb(), rb(), ev(1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 6; i >= 0; i--) push(rb(), rb(), rb(), rb(), rb(), ev(0, 1, 0, 0, 0, i, 0, 0, 0));
    push(rb(), rb(), rb(), rb(), rb(), ev(0, 0, 0, 0, 1, 0, 0, 0, 0));
    anack = (mode == 2) ? 1'b1 : (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
    empty = dir ? rb() : ((mode == 0) ? ($urandom_range(0, 4) == 0) : 1'b0);
    push(rb(), anack, empty, rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
    if (anack) begin
      model_nack = 1'b1;
      go = 1'b0;
    end else begin
      go = dir ? 1'b1 : !empty;
    end
    nbyte = 0;
    while (go) begin
      for (int i = 7; i >= 0; i--) begin
        e = (mode == 3 && nbyte == 1) ? 1'b0 : rb();
        push(e, rb(), rb(), rb(), rb(), ev(0, 0, !dir, dir, 0, i, !dir && i == 0, 0, 0));
      end
      if (!dir) begin
        nk    = (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
        e     = (mode == 0) ? (nbyte < 3 && rb()) : 1'b1;
        empty = (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b1;
        push(e, nk, empty, rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (nk) model_nack = 1'b1;
        go = !nk && e && !empty;
      end else begin
        f   = (mode == 4) ? 1'b1 : (mode == 0) ? ($urandom_range(0, 3) == 0) : 1'b0;
        e   = (mode == 3) ? (nbyte == 0) : (mode == 4) ? 1'b1 : (nbyte < 3 && rb());
        ack = e && !f;
        push(e, rb(), rb(), f, rb(), ev(ack, 0, 0, 0, 0, 0, 0, !f, 0));
        go = ack;
      end
      nbyte++;
    end
    push(rb(), rb(), rb(), rb(), rb(), ev(0, 0, 0, 0, 0, 0, 0, 0, 1));
    for (int i = $urandom_range(0, 2); i > 0; i--) push(1'b0, rb(), rb(), rb(), rb(), ev_idle());
  endtask

  // Drive up to n cycles (all if n < 0) and compare outputs at the falling edge
  task automatic apply(input int n);
    logic [4:0]  s;
    logic [13:0] x;
    int k;
    k = 0;
    done_at = -1;
    while (stim_q.size() > 0 && (n < 0 || k < n)) begin
      s = stim_q.pop_front();
      x = exp_q.pop_front();
      @(posedge clk);
      #1;
      {en, sda, txe, rxf, rw} = s;
      @(negedge clk);
      chk("outs", 32'(obs), 32'(x));
      chk("excl", 32'($countones({wa, wd, rd, rwb, stp}) <= 1), 32'd1);
      if (done && done_at < 0) done_at = k;
      k++;
    end
  endtask

  initial begin
    en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(obs), 32'd0);
    en = 1'b0;
    rst = 1'b0;

    build_txn(1);
    apply(-1);
    chk("write_done_cycle", 32'(done_at - 1), 32'd19);

    build_txn(2);
    apply(-1);
    build_txn(3);
    apply(-1);
    build_txn(4);
    apply(-1);

    // Asynchronous reset in the middle of a data byte (bit 4)
    build_txn(1);
    apply(15);
    #1 rst = 1'b1;
    #1 chk("async_rst_outs", 32'(obs), 32'd0);
    stim_q.delete();
    exp_q.delete();
    model_nack = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1 chk("rst_hold_outs", 32'(obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    build_txn(1);
    apply(-1);

    for (int t = 0; t < 60; t++) begin
      build_txn(0);
      apply(-1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
